flex_counter_bank: RTL and testbench

Bank of `NUM_CH` independent, parametrised flex counters. Each channel supports up or down counting, wrap or saturate mode, synchronous load and a per-channel rollover value. Each channel produces a level rollover flag, a level underflow flag and a one-cycle wrap pulse. The bank is the general timing/event-count resource for controllers that need several programmable counters with shared clocking.

---
 rtl/flex_counter_bank_if.sv | 28 ++
 rtl/flex_counter_bank.sv | 93 +++++++++
 tb/tb_flex_counter_bank.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/flex_counter_bank_if.sv
// Bus bundle for flex_counter_bank: per-channel controls, packed values and
// registered count/flag outputs.
interface flex_counter_bank_if #(
  parameter int unsigned NUM_CNT_BITS = 8,
  parameter int unsigned NUM_CH       = 4
);
  logic [NUM_CH-1:0]              clear;
  logic [NUM_CH-1:0]              count_enable;
  logic [NUM_CH-1:0]              count_down;
  logic [NUM_CH-1:0]              saturate;
  logic [NUM_CH-1:0]              load;
  logic [NUM_CH*NUM_CNT_BITS-1:0] load_val;
  logic [NUM_CH*NUM_CNT_BITS-1:0] rollover_val;
  logic [NUM_CH*NUM_CNT_BITS-1:0] count_out;
  logic [NUM_CH-1:0]              rollover_flag;
  logic [NUM_CH-1:0]              underflow_flag;
  logic [NUM_CH-1:0]              wrap_pulse;

  modport master (
    output clear, count_enable, count_down, saturate, load, load_val, rollover_val,
    input  count_out, rollover_flag, underflow_flag, wrap_pulse
  );

  modport slave (
    input  clear, count_enable, count_down, saturate, load, load_val, rollover_val,
    output count_out, rollover_flag, underflow_flag, wrap_pulse
  );
endinterface

// File: rtl/flex_counter_bank.sv
// Bank of independent up/down, wrap/saturate counters with per-channel
// terminal value, level rollover/underflow flags and a one-cycle wrap pulse.
module flex_counter_bank #(
  parameter int unsigned NUM_CNT_BITS = 8,
  parameter int unsigned NUM_CH       = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  flex_counter_bank_if.slave bus
);
  localparam int unsigned W = NUM_CNT_BITS;
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0]      cnt_q [NUM_CH];
  logic [W-1:0]      cnt_d [NUM_CH];
  logic [NUM_CH-1:0] rf_q, rf_d, uf_q, uf_d, wp_q, wp_d;
  logic [W-1:0]      cur, rv;

  always_comb begin
    cur = '0;
    rv  = '0;
    rf_d = rf_q;
    uf_d = uf_q;
    wp_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      cur = cnt_q[i];
      rv  = bus.rollover_val[i*W +: W];
      if (bus.clear[i]) begin
        cnt_d[i] = '0;
        rf_d[i]  = 1'b0;
        uf_d[i]  = 1'b0;
      end else if (bus.load[i]) begin
        cnt_d[i] = bus.load_val[i*W +: W];
        rf_d[i]  = 1'b0;
        uf_d[i]  = 1'b0;
      end else if (bus.count_enable[i]) begin
        if (rv == '0) begin
          // A zero terminal value parks the channel with everything quiet
          cnt_d[i] = '0;
          rf_d[i]  = 1'b0;
          uf_d[i]  = 1'b0;
        end else if (!bus.count_down[i]) begin
          if (cur < rv) begin
            cnt_d[i] = cur + ONE;
          end else if (bus.saturate[i]) begin
            cnt_d[i] = rv;
          end else begin
            cnt_d[i] = ONE;
            wp_d[i]  = 1'b1;
          end
          rf_d[i] = (cnt_d[i] == rv);
          uf_d[i] = 1'b0;
        end else begin
          if (cur == '0) begin
            if (!bus.saturate[i]) begin
              cnt_d[i] = rv;
              wp_d[i]  = 1'b1;
            end
          end else if (cur > rv) begin
            cnt_d[i] = rv;
          end else begin
            cnt_d[i] = cur - ONE;
          end
          uf_d[i] = (cnt_d[i] == '0);
          rf_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      rf_q <= '0;
      uf_q <= '0;
      wp_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      rf_q <= rf_d;
      uf_q <= uf_d;
      wp_q <= wp_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign bus.count_out[g*W +: W] = cnt_q[g];
  end

  assign bus.rollover_flag  = rf_q;
  assign bus.underflow_flag = uf_q;
  assign bus.wrap_pulse     = wp_q;
endmodule

// File: tb/tb_flex_counter_bank.sv
// Directed self-checking bench for flex_counter_bank (W = 8, 4 channels).
module tb_flex_counter_bank;
  logic clk;
  logic n_rst;
  int   checks;
  int   failures;

  flex_counter_bank_if #(.NUM_CNT_BITS(8), .NUM_CH(4)) bus ();

  flex_counter_bank #(.NUM_CNT_BITS(8), .NUM_CH(4)) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // channel 0 shorthand: count, rollover, underflow, pulse
  task automatic chk0(input string tag, input logic [7:0] c, input logic rf,
                      input logic uf, input logic wp);
    chk({tag, "_cnt"}, {24'd0, bus.count_out[7:0]}, {24'd0, c});
    chk({tag, "_rf"}, {31'd0, bus.rollover_flag[0]}, {31'd0, rf});
    chk({tag, "_uf"}, {31'd0, bus.underflow_flag[0]}, {31'd0, uf});
    chk({tag, "_wp"}, {31'd0, bus.wrap_pulse[0]}, {31'd0, wp});
  endtask

  logic [7:0] up_cnt   [8] = '{8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2};
  logic [7:0] dn_cnt   [7] = '{8'd1, 8'd0, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
  logic [7:0] sat_up   [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5, 8'd5};
  logic [7:0] sat_dn   [7] = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};

  initial begin
    checks = 0;
    failures = 0;
    n_rst = 1'b0;
    bus.clear = '0;
    bus.count_enable = '0;
    bus.count_down = '0;
    bus.saturate = '0;
    bus.load = '0;
    bus.load_val = '0;
    bus.rollover_val = '0;

    // Reset state
    #3;
    chk("rst_cnt", bus.count_out, 32'h0);
    chk("rst_flags", {29'd0, |bus.rollover_flag, |bus.underflow_flag, |bus.wrap_pulse}, 32'h0);
    #9 n_rst = 1'b1;
    tick();
    chk("rst_hold_cnt", bus.count_out, 32'h0);

    // Up, wrap: R = 3
    bus.rollover_val[7:0] = 8'd3;
    bus.count_enable[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk0($sformatf("upw%0d", k), up_cnt[k], up_cnt[k] == 8'd3, 1'b0, (k == 3) || (k == 6));
    end

    // Down, wrap: load 2, R = 4
    bus.count_enable[0] = 1'b0;
    bus.rollover_val[7:0] = 8'd4;
    bus.load[0] = 1'b1;
    bus.load_val[7:0] = 8'd2;
    tick();
    chk0("dnw_ld", 8'd2, 1'b0, 1'b0, 1'b0);
    bus.load[0] = 1'b0;
    bus.count_down[0] = 1'b1;
    bus.count_enable[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk0($sformatf("dnw%0d", k), dn_cnt[k], 1'b0, dn_cnt[k] == 8'd0, k == 2);
    end
    bus.count_enable[0] = 1'b0;
    tick();
    chk0("dnw_idle", 8'd0, 1'b0, 1'b1, 1'b0);

    // Saturate: R = 5
    bus.clear[0] = 1'b1;
    tick();
    chk0("sat_clr", 8'd0, 1'b0, 1'b0, 1'b0);
    bus.clear[0] = 1'b0;
    bus.rollover_val[7:0] = 8'd5;
    bus.saturate[0] = 1'b1;
    bus.count_down[0] = 1'b0;
    bus.count_enable[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk0($sformatf("satu%0d", k), sat_up[k], sat_up[k] == 8'd5, 1'b0, 1'b0);
    end
    bus.count_down[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      chk0($sformatf("satd%0d", k), sat_dn[k], 1'b0, sat_dn[k] == 8'd0, 1'b0);
    end

    // Priority and out-of-range load: R = 6
    bus.saturate[0] = 1'b0;
    bus.count_down[0] = 1'b0;
    bus.rollover_val[7:0] = 8'd6;
    bus.clear[0] = 1'b1;
    bus.load[0] = 1'b1;
    bus.load_val[7:0] = 8'd9;
    bus.count_enable[0] = 1'b1;
    tick();
    chk0("pri_clr", 8'd0, 1'b0, 1'b0, 1'b0);
    bus.clear[0] = 1'b0;
    bus.count_enable[0] = 1'b0;
    tick();
    chk0("pri_ld", 8'd9, 1'b0, 1'b0, 1'b0);
    bus.load[0] = 1'b0;
    bus.count_enable[0] = 1'b1;
    tick();
    chk0("pri_oor", 8'd1, 1'b0, 1'b0, 1'b1);
    bus.count_enable[0] = 1'b0;
    tick();
    chk0("pri_idle", 8'd1, 1'b0, 1'b0, 1'b0);

    // R = 1 up: wraps on every event
    bus.rollover_val[7:0] = 8'd1;
    bus.count_enable[0] = 1'b1;
    tick();
    chk0("r1_a", 8'd1, 1'b1, 1'b0, 1'b1);
    tick();
    chk0("r1_b", 8'd1, 1'b1, 1'b0, 1'b1);

    // Channel independence and R = 0
    bus.count_enable = '0;
    bus.clear[0] = 1'b1;
    bus.load[3:1] = 3'b111;
    bus.load_val[31:8] = {8'd254, 8'd11, 8'd7};
    bus.rollover_val = {8'd255, 8'd20, 8'd20, 8'd0};
    tick();
    chk("ind_ld", bus.count_out, 32'hFE0B_0700);
    bus.clear = '0;
    bus.load = '0;
    bus.count_enable = 4'b1001;
    tick();
    chk("ind_a_cnt", bus.count_out, 32'hFF0B_0700);
    chk("ind_a_rf", {28'd0, bus.rollover_flag}, 32'h8);
    chk("ind_a_wp", {28'd0, bus.wrap_pulse}, 32'h0);
    tick();
    chk("ind_b_cnt", bus.count_out, 32'h010B_0700);
    chk("ind_b_rf", {28'd0, bus.rollover_flag}, 32'h0);
    chk("ind_b_uf", {28'd0, bus.underflow_flag}, 32'h0);
    chk("ind_b_wp", {28'd0, bus.wrap_pulse}, 32'h8);

    // Reset mid-count: R = 2
    bus.count_enable = '0;
    bus.clear = 4'b1111;
    bus.rollover_val[7:0] = 8'd2;
    tick();
    bus.clear = '0;
    bus.count_enable[0] = 1'b1;
    tick();
    tick();
    chk0("mid_pre", 8'd2, 1'b1, 1'b0, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    chk0("mid_rst", 8'd0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_all", bus.count_out, 32'h0);
    #1 n_rst = 1'b1;
    tick();
    chk0("mid_resume", 8'd1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
